regs_uart_fifo: RTL and testbench

Parametrised UART register block with a TX FIFO, an RX FIFO and a maskable interrupt, replacing the single-byte UART register file. It sits between the CPU local bus and the UART serialiser/deserialiser core. It buffers bytes in both directions so software can burst-write or burst-read without polling per byte.

---
 rtl/regs_uart_fifo_if.sv | 28 ++
 rtl/regs_uart_fifo.sv | 187 ++++++++++++++++++
 tb/tb_regs_uart_fifo.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/regs_uart_fifo_if.sv
`default_nettype none
// regs_uart_fifo_if: CPU local-bus write and read channels of the UART register block.
interface regs_uart_fifo_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
);
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              wen;
  logic [STRB_W-1:0] wstrb;
  logic              wready;
  logic [ADDR_W-1:0] raddr;
  logic              ren;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (
    output waddr, wdata, wen, wstrb, raddr, ren,
    input  wready, rdata, rvalid
  );

  modport slave (
    input  waddr, wdata, wen, wstrb, raddr, ren,
    output wready, rdata, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/regs_uart_fifo.sv
`default_nettype none
// regs_uart_fifo (rev 1.0): UART CSR block with TX/RX byte FIFOs and a maskable level irq.
// Define UART_IRQ_EN to build U_IE and the irq flop; otherwise U_IE reads 0 and irq is tied low.
module regs_uart_fifo #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int STRB_W   = DATA_W / 8,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  regs_uart_fifo_if.slave bus,
  output logic            en_out,
  output logic [3:0]      br_out,
  output logic [7:0]      clk_out,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  input  logic            tbusy_in,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            irq
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_ONE = 1;
  localparam logic [RX_AW:0] RX_ONE = 1;

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] A_STAT   = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] A_IE     = ADDR_W'(32'h10);

  logic wr_ctrl, wr_stat, wr_txd, rd_rxd;
  logic en, ovr, ovr_set, ovr_clr;
  logic [3:0] br;
  logic [7:0] clkdiv;
  logic [2:0] ie_rd;
  logic [23:0] stat;
  logic [DATA_W-1:0] rd_mux, rdata_q;
  logic rvalid_q;
  logic unused_ok;

  assign wr_ctrl = bus.wen && (bus.waddr == A_CTRL);
  assign wr_stat = bus.wen && (bus.waddr == A_STAT);
  assign wr_txd  = bus.wen && (bus.waddr == A_TXDATA);
  assign rd_rxd  = bus.ren && (bus.raddr == A_RXDATA);

  assign bus.wready = 1'b1;
  assign unused_ok  = ^{bus.wdata, bus.wstrb};

  always_ff @(posedge clk) begin
    if (rst) begin
      en     <= 1'b0;
      br     <= 4'hF;
      clkdiv <= 8'h00;
    end else if (wr_ctrl) begin
      if (bus.wstrb[0]) begin
        en <= bus.wdata[0];
        br <= bus.wdata[7:4];
      end
      if (bus.wstrb[1]) clkdiv <= bus.wdata[15:8];
    end
  end

  assign en_out  = en;
  assign br_out  = br;
  assign clk_out = clkdiv;

  // TX FIFO: extra pointer MSB distinguishes full from empty
  logic [TX_AW:0] tx_wr, tx_rd, tx_level;
  logic [7:0] tx_mem [TX_DEPTH];
  logic tx_empty, tx_full, tx_push, tx_pop, tx_flush;

  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[TX_AW] != tx_rd[TX_AW]) && (tx_wr[TX_AW-1:0] == tx_rd[TX_AW-1:0]);
  assign tx_level = tx_wr - tx_rd;
  assign tx_valid = !tx_empty && en;
  assign tx_data  = tx_mem[tx_rd[TX_AW-1:0]];
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_push  = wr_txd && bus.wstrb[0] && (!tx_full || tx_pop);
  assign tx_flush = wr_ctrl && bus.wstrb[0] && bus.wdata[1];

  always_ff @(posedge clk) begin
    if (rst || tx_flush) begin
      tx_wr <= '0;
      tx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + TX_ONE;
      if (tx_pop)  tx_rd <= tx_rd + TX_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[TX_AW-1:0]] <= bus.wdata[7:0];
  end

  // RX FIFO: a pop frees the slot a same-cycle push into a full FIFO needs
  logic [RX_AW:0] rx_wr, rx_rd, rx_level;
  logic [7:0] rx_mem [RX_DEPTH];
  logic rx_empty, rx_full, rx_push, rx_pop, rx_flush;

  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[RX_AW] != rx_rd[RX_AW]) && (rx_wr[RX_AW-1:0] == rx_rd[RX_AW-1:0]);
  assign rx_level = rx_wr - rx_rd;
  assign rx_pop   = rd_rxd && !rx_empty;
  assign rx_push  = rx_valid && en && (!rx_full || rx_pop);
  assign rx_flush = wr_ctrl && bus.wstrb[0] && bus.wdata[2];

  always_ff @(posedge clk) begin
    if (rst || rx_flush) begin
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + RX_ONE;
      if (rx_pop)  rx_rd <= rx_rd + RX_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr[RX_AW-1:0]] <= rx_data;
  end

  // Set wins over a same-cycle W1C clear
  assign ovr_set = rx_valid && en && rx_full && !rx_pop;
  assign ovr_clr = wr_stat && bus.wstrb[0] && bus.wdata[4];

  always_ff @(posedge clk) begin
    if (rst)          ovr <= 1'b0;
    else if (ovr_set) ovr <= 1'b1;
    else if (ovr_clr) ovr <= 1'b0;
  end

  assign stat = {8'(rx_level), 8'(tx_level), 2'b00, tbusy_in, ovr,
                 rx_full, !rx_empty, tx_empty, tx_full};

`ifdef UART_IRQ_EN
  logic [2:0] ie;
  logic irq_q;
  logic wr_ie;

  assign wr_ie = bus.wen && (bus.waddr == A_IE);

  always_ff @(posedge clk) begin
    if (rst)                          ie <= 3'b000;
    else if (wr_ie && bus.wstrb[0])   ie <= bus.wdata[2:0];
  end

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= (ie[0] & tx_empty) | (ie[1] & !rx_empty) | (ie[2] & ovr);
  end

  assign ie_rd = ie;
  assign irq   = irq_q;
`else
  assign ie_rd = 3'b000;
  assign irq   = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (bus.raddr)
      A_CTRL:   rd_mux[15:0] = {clkdiv, br, 3'b000, en};
      A_STAT:   rd_mux[23:0] = stat;
      A_RXDATA: rd_mux[7:0]  = rx_empty ? 8'h00 : rx_mem[rx_rd[RX_AW-1:0]];
      A_IE:     rd_mux[2:0]  = ie_rd;
      default:  rd_mux       = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= bus.ren;
      rdata_q  <= bus.ren ? rd_mux : '0;
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
endmodule
`default_nettype wire

// File: tb/tb_regs_uart_fifo.sv
`default_nettype none
// tb_regs_uart_fifo: directed self-checking bench for regs_uart_fifo at default depth 16.
module tb_regs_uart_fifo;
  localparam logic [31:0] A_CTRL = 32'h00, A_STAT = 32'h04, A_TXD = 32'h08;
  localparam logic [31:0] A_RXD = 32'h0C, A_IE = 32'h10;

  logic clk = 1'b0;
  logic rst;
  logic en_out, tx_valid, tx_ready, tbusy_in, rx_valid, irq;
  logic [3:0] br_out;
  logic [7:0] clk_out, tx_data, rx_data;
  int n_assert = 0;
  int n_fail = 0;

  regs_uart_fifo_if #(.ADDR_W(32), .DATA_W(32), .STRB_W(4)) bus ();

  regs_uart_fifo dut (
    .clk(clk), .rst(rst), .bus(bus),
    .en_out(en_out), .br_out(br_out), .clk_out(clk_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tbusy_in(tbusy_in), .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.waddr = a; bus.wdata = d; bus.wstrb = s; bus.wen = 1'b1;
    @(negedge clk);
    bus.wen = 1'b0; bus.wstrb = 4'h0;
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.raddr = a; bus.ren = 1'b1;
    @(negedge clk);
    bus.ren = 1'b0;
    chk(tag, bus.rdata, exp);
    chk({tag, "_rvalid"}, {31'b0, bus.rvalid}, 32'd1);
  endtask

  task automatic rxp(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tx_ready = 1'b0; tbusy_in = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    bus.waddr = '0; bus.wdata = '0; bus.wen = 1'b0; bus.wstrb = '0;
    bus.raddr = '0; bus.ren = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_rvalid", {31'b0, bus.rvalid}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("wready", {31'b0, bus.wready}, 32'd1);
    rdchk("rst_ctrl", A_CTRL, 32'h0000_00F0);
    rdchk("rst_stat", A_STAT, 32'h0000_0002);
    @(negedge clk);
    chk("rvalid_pulse", {31'b0, bus.rvalid}, 32'd0);
    chk("rdata_idle", bus.rdata, 32'd0);

    // control fields and byte lanes
    wr(A_CTRL, 32'h0000_A5F1, 4'h3);
    chk("en_out", {31'b0, en_out}, 32'd1);
    chk("br_out", {28'b0, br_out}, 32'hF);
    chk("clk_out", {24'b0, clk_out}, 32'hA5);
    wr(A_CTRL, 32'h0000_3300, 4'h2);
    rdchk("ctrl_lane1", A_CTRL, 32'h0000_33F1);

    // TX fill past full, then drain
    for (int i = 0; i < 17; i++) wr(A_TXD, 32'(i), 4'h1);
    rdchk("tx_full_stat", A_STAT, 32'h0000_1001);
    chk("tx_valid_full", {31'b0, tx_valid}, 32'd1);
    chk("tx_head_full", {24'b0, tx_data}, 32'h00);
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("tx_drain_valid", {31'b0, tx_valid}, 32'd1);
      chk("tx_drain_data", {24'b0, tx_data}, 32'(i));
      @(negedge clk);
    end
    tx_ready = 1'b0;
    chk("tx_drained_valid", {31'b0, tx_valid}, 32'd0);
    rdchk("tx_empty_stat", A_STAT, 32'h0000_0002);

    wr(A_TXD, 32'h99, 4'h2);
    rdchk("tx_nolane0_stat", A_STAT, 32'h0000_0002);
    tbusy_in = 1'b1;
    rdchk("tbusy_stat", A_STAT, 32'h0000_0022);
    tbusy_in = 1'b0;

    // push into empty FIFO with tx_ready high: no bypass
    tx_ready = 1'b1;
    wr(A_TXD, 32'h5A, 4'h1);
    chk("nobypass_valid", {31'b0, tx_valid}, 32'd1);
    chk("nobypass_data", {24'b0, tx_data}, 32'h5A);
    @(negedge clk);
    chk("nobypass_popped", {31'b0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // RX fill, overflow, W1C
    for (int i = 0; i < 16; i++) rxp(8'hA5 + 8'(i));
    rdchk("rx_full_stat", A_STAT, 32'h0010_000E);
    rxp(8'hEE);
    rdchk("rx_ovr_stat", A_STAT, 32'h0010_001E);
    wr(A_STAT, 32'h10, 4'h1);
    rdchk("ovr_w1c_stat", A_STAT, 32'h0010_000E);

    // same-cycle pop and push while full
    bus.raddr = A_RXD; bus.ren = 1'b1; rx_data = 8'hC0; rx_valid = 1'b1;
    @(negedge clk);
    bus.ren = 1'b0; rx_valid = 1'b0;
    chk("popush_data", bus.rdata, 32'h0000_00A5);
    chk("popush_rvalid", {31'b0, bus.rvalid}, 32'd1);
    rdchk("popush_stat", A_STAT, 32'h0010_000E);
    for (int i = 1; i < 16; i++) rdchk("rx_read", A_RXD, 32'h0000_00A5 + 32'(i));
    rdchk("rx_read_last", A_RXD, 32'h0000_00C0);
    rdchk("rx_read_empty", A_RXD, 32'h0000_0000);
    rdchk("rx_empty_stat", A_STAT, 32'h0000_0002);

    // EN=0 gates RX pushes and tx_valid
    wr(A_CTRL, 32'h0000_33F0, 4'h3);
    rxp(8'h55);
    wr(A_TXD, 32'h77, 4'h1);
    chk("en0_tx_valid", {31'b0, tx_valid}, 32'd0);
    rdchk("en0_stat", A_STAT, 32'h0000_0100);
    wr(A_CTRL, 32'h0000_33F1, 4'h3);
    chk("en1_tx_valid", {31'b0, tx_valid}, 32'd1);
    chk("en1_tx_data", {24'b0, tx_data}, 32'h77);

    // flush both FIFOs
    for (int i = 0; i < 4; i++) wr(A_TXD, 32'h80 + 32'(i), 4'h1);
    for (int i = 0; i < 3; i++) rxp(8'h60 + 8'(i));
    rdchk("preflush_stat", A_STAT, 32'h0003_0504);
    wr(A_CTRL, 32'h0000_0007, 4'h1);
    chk("flush_tx_valid", {31'b0, tx_valid}, 32'd0);
    rdchk("flush_stat", A_STAT, 32'h0000_0002);
    rdchk("flush_ctrl", A_CTRL, 32'h0000_3301);

    // unmapped and write-only reads
    wr(32'h14, 32'hFFFF_FFFF, 4'hF);
    rdchk("unmapped_rd", 32'h14, 32'h0);
    rdchk("txdata_rd", A_TXD, 32'h0);
    rdchk("unmapped_stat", A_STAT, 32'h0000_0002);

`ifdef UART_IRQ_EN
    wr(A_IE, 32'h2, 4'h1);
    rdchk("ie_rd", A_IE, 32'h2);
    chk("irq_idle", {31'b0, irq}, 32'd0);
    rxp(8'h42);
    chk("irq_rx_1cyc", {31'b0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_rx_2cyc", {31'b0, irq}, 32'd1);
    rdchk("irq_rx_data", A_RXD, 32'h42);
    chk("irq_pop_1cyc", {31'b0, irq}, 32'd1);
    @(negedge clk);
    chk("irq_pop_2cyc", {31'b0, irq}, 32'd0);
    wr(A_IE, 32'h1, 4'h1);
    chk("irq_txe_1cyc", {31'b0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_txe_2cyc", {31'b0, irq}, 32'd1);
    wr(A_IE, 32'h0, 4'h1);
    chk("irq_off_1cyc", {31'b0, irq}, 32'd1);
    @(negedge clk);
    chk("irq_off_2cyc", {31'b0, irq}, 32'd0);
`else
    wr(A_IE, 32'h7, 4'h1);
    rdchk("ie_rd_off", A_IE, 32'h0);
    rxp(8'h42);
    repeat (2) @(negedge clk);
    chk("irq_tied", {31'b0, irq}, 32'd0);
    rdchk("rx_data_off", A_RXD, 32'h42);
`endif

    // reset mid-operation
    wr(A_TXD, 32'h11, 4'h1);
    for (int i = 0; i < 17; i++) rxp(8'(i));
    rdchk("prerst_stat", A_STAT, 32'h0010_011C);
    bus.raddr = A_CTRL; bus.ren = 1'b1; rst = 1'b1;
    @(negedge clk);
    bus.ren = 1'b0; rst = 1'b0;
    chk("midrst_rvalid", {31'b0, bus.rvalid}, 32'd0);
    chk("midrst_rdata", bus.rdata, 32'd0);
    chk("midrst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("midrst_irq", {31'b0, irq}, 32'd0);
    rdchk("midrst_ctrl", A_CTRL, 32'h0000_00F0);
    rdchk("midrst_stat", A_STAT, 32'h0000_0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
